// File: rtl/usb1bd_pkg.sv
// usb1bd_pkg: shared constants and types for the USB device TX packet assembler.
//   - PID codes (low nibble; the PID byte is {~pid, pid})
//   - FSM state enum
//   - USB CRC16 init/poly and a 16-bit bit-reverse helper
package usb1bd_pkg;

    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;
    localparam logic [3:0] PID_NYET  = 4'h6;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_DATA2 = 4'h7;
    localparam logic [3:0] PID_MDATA = 4'hF;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PID    = 3'd1,
        ST_DATA   = 3'd2,
        ST_CRC_LO = 3'd3,
        ST_CRC_HI = 3'd4,
        ST_ABORT  = 3'd5
    } state_e;

    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

endpackage

// File: rtl/usb1bd_pkt_asm_if.sv
// usb1bd_pkt_asm_if: command, UTMI TX and TX-FIFO signals of the packet assembler.
//   master : the assembler (accepts commands, drives UTMI bytes, pops the FIFO)
//   slave  : the surrounding logic (command source, UTMI PHY, FIFO)
interface usb1bd_pkt_asm_if #(
    parameter int LEN_W = 7
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_is_data;
    logic [3:0]       cmd_pid;
    logic [LEN_W-1:0] cmd_len;

    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_first;
    logic             tx_valid_last;

    logic [7:0]       tx_fifo_data;
    logic             tx_fifo_re;
    logic             tx_fifo_empty;

    modport master (
        input  cmd_valid, cmd_is_data, cmd_pid, cmd_len,
        output cmd_ready,
        output tx_data, tx_valid, tx_first, tx_valid_last,
        input  tx_ready,
        input  tx_fifo_data, tx_fifo_empty,
        output tx_fifo_re
    );

    modport slave (
        output cmd_valid, cmd_is_data, cmd_pid, cmd_len,
        input  cmd_ready,
        input  tx_data, tx_valid, tx_first, tx_valid_last,
        output tx_ready,
        output tx_fifo_data, tx_fifo_empty,
        input  tx_fifo_re
    );

endinterface

// File: rtl/usb1bd_crc16.sv
// usb1bd_crc16: byte-parallel USB CRC16 update (poly 0x8005), combinational.
//   crc_in  : running CRC register (non-reflected form)
//   data    : byte to fold in, consumed LSB first as on the wire
//   crc_out : updated CRC register
module usb1bd_crc16
    import usb1bd_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else                 c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end

endmodule

// File: rtl/usb1bd_pkt_asm.sv
// usb1bd_pkt_asm: USB device TX packet assembler on the UTMI path.
//   clk, rst_n   : clock, synchronous active-low reset
//   bus          : command handshake, UTMI TX byte stream, TX FIFO (show-ahead)
//   abort        : abandon the packet in flight; an FF byte with last=1 is sent
//   underrun     : one-cycle pulse (once per packet) when the FIFO ran dry in DATA
//   pkt_sent_cnt : completed packets, wrapping
//   state        : current FSM state, for debug
module usb1bd_pkt_asm
    import usb1bd_pkg::*;
#(
    parameter int MAX_PKT_LEN = 64,
    parameter int LEN_W       = $clog2(MAX_PKT_LEN + 1),
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    usb1bd_pkt_asm_if.master   bus,
    input  logic               abort,
    output logic               underrun,
    output logic [CNT_W-1:0]   pkt_sent_cnt,
    output logic [2:0]         state
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

    state_e           state_q, state_d;
    logic [3:0]       pid_q, pid_d;
    logic             is_data_q, is_data_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      crc_q, crc_d, crc_nx;
    logic             und_seen_q, und_seen_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      crc_wire;

    usb1bd_crc16 u_crc (
        .crc_in  (crc_q),
        .data    (bus.tx_fifo_data),
        .crc_out (crc_nx)
    );

    // Value sent on the wire: reflected and complemented, low byte first.
    assign crc_wire     = ~reflect16(crc_q);
    assign pkt_sent_cnt = cnt_q;
    assign state        = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pid_q      <= 4'h0;
            is_data_q  <= 1'b0;
            rem_q      <= '0;
            crc_q      <= CRC16_INIT;
            und_seen_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pid_q      <= pid_d;
            is_data_q  <= is_data_d;
            rem_q      <= rem_d;
            crc_q      <= crc_d;
            und_seen_q <= und_seen_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        pid_d             = pid_q;
        is_data_d         = is_data_q;
        rem_d             = rem_q;
        crc_d             = crc_q;
        und_seen_d        = und_seen_q;
        cnt_d             = cnt_q;
        bus.cmd_ready     = 1'b0;
        bus.tx_data       = 8'h00;
        bus.tx_valid      = 1'b0;
        bus.tx_first      = 1'b0;
        bus.tx_valid_last = 1'b0;
        bus.tx_fifo_re    = 1'b0;
        underrun          = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // abort is ignored here, including in the capture cycle
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_d    = ST_PID;
                    pid_d      = bus.cmd_pid;
                    is_data_d  = bus.cmd_is_data;
                    rem_d      = !bus.cmd_is_data ? '0 :
                                 (bus.cmd_len > MAX_LEN) ? MAX_LEN : bus.cmd_len;
                    crc_d      = CRC16_INIT;
                    und_seen_d = 1'b0;
                end
            end

            ST_PID: begin
                bus.tx_valid      = 1'b1;
                bus.tx_data       = {~pid_q, pid_q};
                bus.tx_first      = 1'b1;
                bus.tx_valid_last = !is_data_q;
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (bus.tx_ready) begin
                    if (!is_data_q) begin
                        state_d = ST_IDLE;
                        cnt_d   = cnt_q + 1'b1;
                    end else if (rem_q == '0) begin
                        state_d = ST_CRC_LO;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                bus.tx_data  = bus.tx_fifo_data;
                bus.tx_valid = !bus.tx_fifo_empty;
                if (bus.tx_fifo_empty && !und_seen_q) begin
                    underrun   = 1'b1;
                    und_seen_d = 1'b1;
                end
                // A byte taken in the abort cycle is still popped and counted.
                if (!bus.tx_fifo_empty && bus.tx_ready) begin
                    bus.tx_fifo_re = 1'b1;
                    crc_d          = crc_nx;
                    if (rem_q != '0) rem_d = rem_q - 1'b1;
                    if (rem_q <= LEN_W'(1)) state_d = ST_CRC_LO;
                end
                if (abort) state_d = ST_ABORT;
            end

            ST_CRC_LO: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = crc_wire[7:0];
                if (abort)             state_d = ST_ABORT;
                else if (bus.tx_ready) state_d = ST_CRC_HI;
            end

            ST_CRC_HI: begin
                bus.tx_valid      = 1'b1;
                bus.tx_data       = crc_wire[15:8];
                bus.tx_valid_last = 1'b1;
                if (abort) begin
                    state_d = ST_ABORT;
                end else if (bus.tx_ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            ST_ABORT: begin
                // FF with last marks the packet with a bit-stuff error
                bus.tx_valid      = 1'b1;
                bus.tx_data       = 8'hFF;
                bus.tx_valid_last = 1'b1;
                if (bus.tx_ready) state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_usb1bd_pkt_asm.sv
module tb_usb1bd_pkt_asm;
    import usb1bd_pkg::*;

    localparam int MAXL  = 16;
    localparam int LW    = 5;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort = 1'b0;
    logic          underrun;
    logic [CW-1:0] pkt_sent_cnt;
    logic [2:0]    state;

    usb1bd_pkt_asm_if #(.LEN_W(LW)) bus();

    usb1bd_pkt_asm #(.MAX_PKT_LEN(MAXL), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .abort        (abort),
        .underrun     (underrun),
        .pkt_sent_cnt (pkt_sent_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    // FIFO model (show-ahead)
    logic [7:0] fmem [0:63];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;
    logic       hold_empty = 1'b0;
    logic       flush = 1'b0;

    assign bus.tx_fifo_data  = fmem[rd_ptr];
    assign bus.tx_fifo_empty = (rd_ptr == wr_ptr) || hold_empty;

    always @(posedge clk) begin
        if (flush) rd_ptr <= wr_ptr;
        else if (bus.tx_fifo_re && !bus.tx_fifo_empty) rd_ptr <= rd_ptr + 6'd1;
    end

    typedef struct {
        logic            is_data;
        logic [3:0]      pid;
        logic [LW-1:0]   len;
        int              n_load;
        bit              rnd;
        int              gap;
        int              abort_at;
        int              exp_n;
        logic [19:0][7:0] exp;
        int              exp_re;
        int              exp_und;
        bit              cnt_inc;
    } vec_t;

    vec_t tbl [0:15];
    int   n_rows = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cnt_exp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Reflected-form reference CRC over payload bytes 0x31, 0x32, ...
    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            b = 8'h31 + 8'(i);
            for (int j = 0; j < 8; j++) begin
                if (c[0] ^ b[j]) c = (c >> 1) ^ 16'hA001;
                else             c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic add_row(input logic is_data, input logic [3:0] pid, input logic [7:0] pid_byte,
                           input int len, input int n_load, input int n_sent, input bit rnd,
                           input int gap, input int abort_at, input int und);
        vec_t v;
        logic [15:0] c;
        v.is_data  = is_data;
        v.pid      = pid;
        v.len      = LW'(len);
        v.n_load   = n_load;
        v.rnd      = rnd;
        v.gap      = gap;
        v.abort_at = abort_at;
        v.exp      = '0;
        v.exp[0]   = pid_byte;
        v.exp_n    = 1;
        v.exp_re   = n_sent;
        v.exp_und  = und;
        v.cnt_inc  = (abort_at < 0);
        for (int i = 0; i < n_sent; i++) v.exp[1+i] = 8'h31 + 8'(i);
        v.exp_n = 1 + n_sent;
        if (abort_at >= 0) begin
            v.exp[v.exp_n] = 8'hFF;
            v.exp_n++;
        end else if (is_data) begin
            c = crc_model(n_sent);
            v.exp[v.exp_n]   = c[7:0];
            v.exp[v.exp_n+1] = c[15:8];
            v.exp_n += 2;
        end
        tbl[n_rows] = v;
        n_rows++;
    endtask

    task automatic do_flush();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic run_row(input int r);
        vec_t v;
        logic [7:0] gd [0:31];
        bit   gf [0:31];
        bit   gl [0:31];
        int   ngot, popped, und, gapc;
        bit   done, ab_done, stall_p;
        logic [7:0] stall_d;
        v = tbl[r];
        ngot = 0; popped = 0; und = 0; gapc = 0;
        done = 0; ab_done = 0; stall_p = 0; stall_d = 8'h00;
        for (int i = 0; i < v.n_load; i++) begin
            fmem[wr_ptr] = 8'h31 + 8'(i);
            wr_ptr = wr_ptr + 6'd1;
        end
        @(posedge clk); #1;
        bus.cmd_valid   = 1'b1;
        bus.cmd_is_data = v.is_data;
        bus.cmd_pid     = v.pid;
        bus.cmd_len     = v.len;
        bus.tx_ready    = 1'b1;
        @(negedge clk);
        chk($sformatf("row%0d cmd_ready_idle", r), 32'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            bus.tx_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hold_empty   = (v.gap >= 0) && (popped == v.gap) && (gapc < 5);
            if (v.abort_at >= 0 && popped == v.abort_at && !ab_done) begin
                abort = 1'b1; bus.tx_ready = 1'b0; ab_done = 1;
            end else begin
                abort = 1'b0;
            end
            @(negedge clk);
            if (c == 0) chk($sformatf("row%0d latency", r), 32'(bus.tx_valid), 1);
            if (hold_empty) begin
                chk($sformatf("row%0d gap_valid", r), 32'(bus.tx_valid), 0);
                gapc++;
            end
            if (stall_p && bus.tx_valid) chk($sformatf("row%0d stall_stable", r), 32'(bus.tx_data), 32'(stall_d));
            stall_p = bus.tx_valid && !bus.tx_ready && !abort;
            stall_d = bus.tx_data;
            if (underrun) und++;
            if (bus.tx_fifo_re) popped++;
            if (bus.tx_valid && bus.tx_ready) begin
                if (ngot < 32) begin
                    gd[ngot] = bus.tx_data; gf[ngot] = bus.tx_first; gl[ngot] = bus.tx_valid_last;
                end
                ngot++;
                if (bus.tx_valid_last) done = 1;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; hold_empty = 1'b0; bus.tx_ready = 1'b1;
        chk($sformatf("row%0d completed", r), 32'(done), 1);
        chk($sformatf("row%0d nbytes", r), 32'(ngot), 32'(v.exp_n));
        for (int i = 0; i < v.exp_n && i < ngot && i < 32; i++) begin
            chk($sformatf("row%0d byte%0d", r, i), 32'(gd[i]), 32'(v.exp[i]));
            chk($sformatf("row%0d first%0d", r, i), 32'(gf[i]), 32'(i == 0));
            chk($sformatf("row%0d last%0d", r, i), 32'(gl[i]), 32'(i == v.exp_n - 1));
        end
        chk($sformatf("row%0d fifo_re", r), 32'(popped), 32'(v.exp_re));
        chk($sformatf("row%0d underrun", r), 32'(und), 32'(v.exp_und));
        if (v.cnt_inc) cnt_exp++;
        @(negedge clk);
        chk($sformatf("row%0d cmd_ready_after", r), 32'(bus.cmd_ready), 1);
        chk($sformatf("row%0d state_idle", r), 32'(state), 0);
        chk($sformatf("row%0d pkt_cnt", r), 32'(pkt_sent_cnt), 32'(cnt_exp));
        do_flush();
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_is_data = 1'b0; bus.cmd_pid = 4'h0;
        bus.cmd_len = '0; bus.tx_ready = 1'b1;
        for (int i = 0; i < 64; i++) fmem[i] = 8'h00;

        //      data pid        byte   len ld sent rnd gap ab und
        add_row(0, PID_ACK,   8'hD2,  5, 0, 0, 0, -1, -1, 0);
        add_row(0, PID_NAK,   8'h5A,  0, 0, 0, 0, -1, -1, 0);
        add_row(0, PID_STALL, 8'h1E,  0, 0, 0, 0, -1, -1, 0);
        add_row(0, PID_NYET,  8'h96,  0, 0, 0, 1, -1, -1, 0);
        add_row(1, PID_DATA0, 8'hC3,  0, 0, 0, 0, -1, -1, 0);
        tbl[4].exp[1] = 8'h00; tbl[4].exp[2] = 8'h00;
        add_row(1, PID_DATA1, 8'h4B,  9, 9, 9, 0, -1, -1, 0);
        tbl[5].exp[10] = 8'hC8; tbl[5].exp[11] = 8'hB4;
        add_row(1, PID_DATA0, 8'hC3,  4, 4, 4, 1, -1, -1, 0);
        add_row(1, PID_DATA0, 8'hC3,  8, 8, 8, 0,  3, -1, 1);
        add_row(1, PID_DATA2, 8'h87, 31, 20, 16, 0, -1, -1, 0);
        add_row(1, PID_DATA1, 8'h4B,  6, 6, 2, 0, -1,  2, 0);
        add_row(1, PID_MDATA, 8'h0F,  1, 1, 1, 1, -1, -1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset cmd_ready", 32'(bus.cmd_ready), 1);
        chk("reset tx_valid", 32'(bus.tx_valid), 0);
        chk("reset tx_first", 32'(bus.tx_first), 0);
        chk("reset tx_last", 32'(bus.tx_valid_last), 0);
        chk("reset fifo_re", 32'(bus.tx_fifo_re), 0);
        chk("reset underrun", 32'(underrun), 0);
        chk("reset pkt_cnt", 32'(pkt_sent_cnt), 0);
        chk("reset state", 32'(state), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int r = 0; r < n_rows; r++) run_row(r);

        // abort while idle must not disturb anything
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("idle_abort state", 32'(state), 0);
        chk("idle_abort tx_valid", 32'(bus.tx_valid), 0);

        // reset in the middle of a data packet
        begin
            int popped;
            popped = 0;
            for (int i = 0; i < 4; i++) begin
                fmem[wr_ptr] = 8'h31 + 8'(i);
                wr_ptr = wr_ptr + 6'd1;
            end
            @(posedge clk); #1;
            bus.cmd_valid = 1'b1; bus.cmd_is_data = 1'b1; bus.cmd_pid = PID_DATA0;
            bus.cmd_len = LW'(4); bus.tx_ready = 1'b1;
            @(posedge clk); #1 bus.cmd_valid = 1'b0;
            for (int c = 0; c < 50 && popped < 1; c++) begin
                @(negedge clk);
                if (bus.tx_fifo_re) popped++;
                @(posedge clk); #1;
            end
            chk("midrst reached_data", 32'(state), 32'(ST_DATA));
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("midrst tx_valid", 32'(bus.tx_valid), 0);
            chk("midrst cmd_ready", 32'(bus.cmd_ready), 1);
            chk("midrst pkt_cnt", 32'(pkt_sent_cnt), 0);
            #1 rst_n = 1'b1;
            cnt_exp = 0;
            do_flush();
            run_row(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/usb1bd_pkt_asm.md
Name: usb1bd_pkt_asm

Overview:
Parametrised next-generation USB device packet assembler on the UTMI TX path. It accepts one command per packet:
- Handshake (ACK/NAK/STALL/NYET): a single PID byte.
- Data (DATA0/DATA1/DATA2/MDATA): PID byte, 0..MAX_PKT_LEN payload bytes from the TX FIFO, then the CRC16 (low byte first).

New over the previous assembler: explicit byte count with max-length clamp, command valid/ready handshake, mid-packet abort with bit-stuff-error marking, FIFO-underrun detection, and a transmitted-packet counter.

Parameters:
MAX_PKT_LEN, 64, largest payload in bytes (8..1023).
LEN_W, $clog2(MAX_PKT_LEN+1), width of length fields.
CNT_W, 16, width of sent-packet counter.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  block idle and able to accept
cmd_is_data  in  1  1 = data packet, 0 = handshake
cmd_pid  in  4  PID code (low nibble; high nibble generated as ~cmd_pid)
cmd_len  in  LEN_W  payload bytes (data only)
abort  in  1  abandon current packet
tx_data  out  8  UTMI byte
tx_valid  out  1  UTMI valid
tx_ready  in  1  UTMI byte accepted
tx_first  out  1  high with the PID byte
tx_valid_last  out  1  high with the final byte
tx_fifo_data  in  8  FIFO head byte (show-ahead)
tx_fifo_re  out  1  pop FIFO head
tx_fifo_empty  in  1  FIFO empty
underrun  out  1  one-cycle pulse: FIFO empty when a payload byte was needed
pkt_sent_cnt  out  CNT_W  completed packets, wraps
state  out  3  debug: current FSM state

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, cmd_ready=1, tx_valid=0, tx_first=0, tx_valid_last=0, tx_fifo_re=0, underrun=0, pkt_sent_cnt=0, CRC=16'hFFFF, length counters=0. Reset mid-packet drops tx_valid on the next edge. No partial-packet cleanup is done.
- Transfer rule: a byte moves when tx_valid & tx_ready at a clk edge. tx_data is stable while tx_valid=1 and tx_ready=0.
- Command acceptance: cmd_ready=1 only in IDLE. A command is captured on cmd_valid & cmd_ready. cmd_len is clamped to MAX_PKT_LEN. tx_valid rises the cycle after capture (latency 1).
- FSM states: IDLE, PID, DATA, CRC_LO, CRC_HI, ABORT.
  - IDLE -> PID on command.
  - PID: tx_data={~pid,pid}, tx_first=1.
    - Handshake: tx_valid_last=1; on transfer -> IDLE.
    - Data with len=0: on transfer -> CRC_LO.
    - Data with len>0: on transfer -> DATA.
  - DATA: tx_data=tx_fifo_data; tx_valid=!tx_fifo_empty.
    - On transfer: tx_fifo_re=1 (same cycle, combinational), CRC updated, remaining count decremented.
    - When remaining reaches 0 -> CRC_LO.
  - CRC_LO: tx_data=~reflect(crc)[7:0]; on transfer -> CRC_HI.
  - CRC_HI: tx_data=~reflect(crc)[15:8], tx_valid_last=1; on transfer -> IDLE and pkt_sent_cnt+1.
- Underrun: in DATA with tx_fifo_empty, pulse underrun once per packet. tx_valid=0 (no byte sent). Wait for data; no timeout.
- CRC: USB CRC16, poly 0x8005, init 0xFFFF, LSB-first per byte, output complemented, low byte sent first. The init is re-applied on command capture.
- Abort: if asserted in PID/DATA/CRC_LO/CRC_HI -> ABORT. ABORT drives tx_data=8'hFF, tx_valid=1, tx_valid_last=1 (bit-stuff error marker), waits for transfer, then -> IDLE.
  - pkt_sent_cnt is not incremented.
  - The FIFO is not flushed; that is the owner's responsibility.
  - abort in IDLE is ignored.
  - abort in the same cycle as a transfer: abort wins; the transferred byte counts as sent and the FIFO is popped.
- Simultaneous events:
  - cmd_valid in any non-IDLE state is held off (cmd_ready=0).
  - Command capture and abort in the same cycle: the command is captured and abort is ignored.
- Width rules: remaining counter is LEN_W bits and never underflows (guarded at 0). pkt_sent_cnt wraps from all-ones to 0.

Decomposition:
- Package usb1bd_pkg holds:
  - PID constants (ACK=4'h2, NAK=4'hA, STALL=4'hE, NYET=4'h6, DATA0=4'h3, DATA1=4'hB, DATA2=4'h7, MDATA=4'hF).
  - The state enum typedef.
  - The CRC16 init/poly constants.
- The existing usb1bd_crc16 byte-parallel combinational sub-module is instantiated for the CRC update. No other sub-module.

Test Plan:
1. Handshake ACK, tx_ready always 1 -> single byte 0xD2 with tx_first=1, tx_valid_last=1; cmd_ready back to 1 the following cycle; pkt_sent_cnt=1.
2. DATA0, len=0 -> bytes C3, 00, 00; tx_valid_last only on the third byte.
3. DATA1, len=9, FIFO "123456789" -> 4B, 31..39, C8, B4; exactly 9 tx_fifo_re pulses.
4. DATA0, len=4, tx_ready toggling 1/0 randomly -> tx_data stable while stalled; output stream identical to the stall-free case.
5. DATA0, len=8 with FIFO empty after 3 bytes for 5 cycles -> one underrun pulse, tx_valid=0 during the gap; the packet resumes and completes correctly.
6. Abort after the 2nd payload byte -> byte FF with tx_valid_last=1, return to IDLE, pkt_sent_cnt unchanged; rst_n low mid-DATA -> tx_valid=0 on the next edge.
